problema1_mem_mover: RTL and testbench

//   Avalon-MM master (initiator) that drives the 32-bit on-chip memory slave from logic:

---
 rtl/problema1_mover_pkg.sv | 6 +
 rtl/problema1_mover_addr_gen.sv | 42 ++++
 rtl/problema1_mem_mover.sv | 77 +++++++
 tb/tb_problema1_mem_mover.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/problema1_mover_pkg.sv
// problema1_mover_pkg: shared types and constants for the memory mover
package problema1_mover_pkg;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [3:0] BE_ALL = 4'hF;
endpackage

// File: rtl/problema1_mover_addr_gen.sv
// problema1_mover_addr_gen: source/destination address walkers and remaining-word counter
module problema1_mover_addr_gen
  import problema1_mover_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step_src,
  input  logic              i_step_dst,
  input  logic [ADDR_W-1:0] i_src_base,
  input  logic [ADDR_W-1:0] i_dst_base,
  input  logic [CNT_W-1:0]  i_count,
  output logic [ADDR_W-1:0] o_src,
  output logic [ADDR_W-1:0] o_dst,
  output logic              o_last
);
  logic [ADDR_W-1:0] r_src, r_dst;
  logic [CNT_W-1:0] r_rem;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src <= '0;
      r_dst <= '0;
      r_rem <= '0;
    end else if (i_load) begin
      r_src <= {i_src_base[ADDR_W-1:2], 2'b00};
      r_dst <= {i_dst_base[ADDR_W-1:2], 2'b00};
      r_rem <= i_count;
    end else begin
      if (i_step_src) r_src <= r_src + ADDR_W'(BYTES_PER_WORD);
      if (i_step_dst) begin
        r_dst <= r_dst + ADDR_W'(BYTES_PER_WORD);
        r_rem <= r_rem - CNT_W'(1);
      end
    end
  end
  assign o_src = r_src;
  assign o_dst = r_dst;
  assign o_last = r_rem == CNT_W'(1);
endmodule

// File: rtl/problema1_mem_mover.sv
// problema1_mem_mover: Avalon-MM master that copies or fills a block of 32-bit words
module problema1_mem_mover
  import problema1_mover_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [31:0]       fill_pattern,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);
  state_t r_state, w_next;
  logic r_mode;
  logic [31:0] r_wdata;
  logic w_load, w_step_src, w_step_dst, w_last;
  logic [ADDR_W-1:0] w_src, w_dst;
  assign w_load = r_state == IDLE && start;
  assign w_step_src = r_state == RD_REQ && !avm_waitrequest;
  assign w_step_dst = r_state == WR_REQ && !avm_waitrequest;
  problema1_mover_addr_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_addr (
    .clk(clk),
    .rst(reset),
    .i_load(w_load),
    .i_step_src(w_step_src),
    .i_step_dst(w_step_dst),
    .i_src_base(src_base),
    .i_dst_base(dst_base),
    .i_count(word_count),
    .o_src(w_src),
    .o_dst(w_dst),
    .o_last(w_last)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_mode <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) r_mode <= mode;
      if (w_load && mode) r_wdata <= fill_pattern;
      else if (r_state == RD_WAIT && avm_readdatavalid) r_wdata <= avm_readdata;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = word_count == '0 ? FINISH : mode ? WR_REQ : RD_REQ;
      RD_REQ:  if (!avm_waitrequest) w_next = RD_WAIT;
      RD_WAIT: if (avm_readdatavalid) w_next = WR_REQ;
      WR_REQ:  if (!avm_waitrequest) w_next = w_last ? FINISH : r_mode ? WR_REQ : RD_REQ;
      default: w_next = IDLE;
    endcase
    busy = r_state == RD_REQ || r_state == RD_WAIT || r_state == WR_REQ;
    done = r_state == FINISH;
    avm_read = r_state == RD_REQ;
    avm_write = r_state == WR_REQ;
    avm_address = avm_read ? w_src : avm_write ? w_dst : '0;
  end
  assign avm_writedata = r_wdata;
  assign avm_byteenable = BE_ALL;
endmodule

// File: tb/tb_problema1_mem_mover.sv
// tb_problema1_mem_mover: memory slave model with stall/latency injection and a
// sequential copy/fill reference model over an array image of the memory.
module tb_problema1_mem_mover;
  logic clk = 0, reset = 1, start = 0, mode = 0;
  logic [11:0] src_base = 0, dst_base = 0;
  logic [10:0] word_count = 0;
  logic [31:0] fill_pattern = 0;
  logic busy, done, avm_read, avm_write;
  logic [11:0] avm_address;
  logic [31:0] avm_writedata;
  logic [3:0] avm_byteenable;
  logic [31:0] avm_readdata = 0;
  logic avm_readdatavalid = 0, avm_waitrequest = 0;
  int n_tests = 0, n_fail = 0, n_viol = 0, n_rd = 0, n_req = 0;
  int stall_mode = 0, lat = 1;
  bit spur = 0;
  logic [31:0] mem [1024];
  logic [11:0] wq_a[$];
  logic [31:0] wq_d[$];

  typedef struct {
    logic md; logic [11:0] s, d; logic [10:0] n; logic [31:0] p;
    int stl; int cyc; int bsy; bit rep; bit fin; string nm;
  } vec_t;

  problema1_mem_mover dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_base(src_base), .dst_base(dst_base), .word_count(word_count),
    .fill_pattern(fill_pattern), .busy(busy), .done(done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Slave: accepts requests on edges with waitrequest low, answers reads after lat cycles
  initial begin
    int rd_cnt = 0, ws = 0;
    logic [31:0] rd_q = 0;
    logic pw = 0, pr = 0, pwr = 0;
    logic [11:0] pa = 0;
    logic [31:0] pd = 0;
    forever begin
      @(negedge clk);
      if (!reset && pw && (pr || pwr) &&
          {avm_read, avm_write, avm_address, avm_writedata} != {pr, pwr, pa, pd}) begin
        n_viol++;
        $display("FAIL stall_hold: got r%0b w%0b a=0x%0h d=0x%0h expected r%0b w%0b a=0x%0h d=0x%0h",
                 avm_read, avm_write, avm_address, avm_writedata, pr, pwr, pa, pd);
      end
      if (avm_read && avm_write) begin
        n_viol++;
        $display("FAIL rd_wr_excl: got read=1 write=1 expected not both");
      end
      avm_readdatavalid = 0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin avm_readdatavalid = 1; avm_readdata = rd_q; end
      end else if (spur && $urandom_range(3) == 0) begin
        avm_readdatavalid = 1;
        avm_readdata = $urandom;
      end
      avm_waitrequest = stall_mode == 1 ? ($urandom_range(2) == 0) : (stall_mode == 2 && avm_write && ws < 2);
      if (stall_mode == 2 && avm_write) ws = ws < 2 ? ws + 1 : 0;
      if (avm_read || avm_write) n_req++;
      if (!reset && avm_read && !avm_waitrequest) begin
        n_rd++;
        rd_q = mem[avm_address[11:2]];
        rd_cnt = lat > 0 ? lat : int'($urandom_range(3, 1));
      end
      if (!reset && avm_write && !avm_waitrequest) begin
        mem[avm_address[11:2]] = avm_writedata;
        wq_a.push_back(avm_address);
        wq_d.push_back(avm_writedata);
      end
      pw = avm_waitrequest; pr = avm_read; pwr = avm_write; pa = avm_address; pd = avm_writedata;
    end
  end

  task automatic run_job(input vec_t v);
    logic [31:0] mm [1024];
    logic [11:0] ea[$];
    logic [31:0] ed[$];
    int cyc = 0, got = -1, dn = 0, bz = 0, xb = 0, rd0, rq0;
    mm = mem;
    for (int i = 0; i < int'(v.n); i++) begin
      logic [11:0] sa, da;
      logic [31:0] w;
      sa = (v.s & 12'hFFC) + 12'(4 * i);
      da = (v.d & 12'hFFC) + 12'(4 * i);
      w = v.md ? v.p : mm[sa[11:2]];
      mm[da[11:2]] = w;
      ea.push_back(da);
      ed.push_back(w);
    end
    stall_mode = v.stl;
    @(negedge clk);
    wq_a.delete(); wq_d.delete();
    rd0 = n_rd; rq0 = n_req;
    start = 1; mode = v.md; src_base = v.s; dst_base = v.d; word_count = v.n; fill_pattern = v.p;
    while (cyc < 2000 && got < 0) begin
      @(negedge clk);
      cyc++;
      start = v.rep && cyc % 3 == 0;
      if (v.rep) begin
        mode = ~v.md; word_count = 11'($urandom_range(20, 1));
        src_base = 12'($urandom); dst_base = 12'($urandom); fill_pattern = $urandom;
      end
      if (busy) bz++;
      if (done) begin dn++; got = cyc; end
    end
    start = v.fin;
    repeat (4) begin
      @(negedge clk);
      start = 0;
      if (done) dn++;
      if (busy) xb++;
    end
    if (v.cyc >= 0) chk({v.nm, " done_cycle"}, 64'(got), 64'(v.cyc));
    else chk({v.nm, " done_seen"}, 64'(got > 0), 64'd1);
    if (v.bsy >= 0) chk({v.nm, " busy_cycles"}, 64'(bz), 64'(v.bsy));
    chk({v.nm, " done_pulses"}, 64'(dn), 64'd1);
    chk({v.nm, " busy_after"}, 64'(xb), 64'd0);
    chk({v.nm, " reads"}, 64'(n_rd - rd0), v.md ? 64'd0 : 64'(v.n));
    if (v.n == 0) chk({v.nm, " bus_requests"}, 64'(n_req - rq0), 64'd0);
    chk({v.nm, " nwrites"}, 64'(wq_a.size()), 64'(ea.size()));
    for (int i = 0; i < ea.size() && i < wq_a.size(); i++) begin
      chk($sformatf("%s w%0d addr", v.nm, i), 64'(wq_a[i]), 64'(ea[i]));
      chk($sformatf("%s w%0d data", v.nm, i), 64'(wq_d[i]), 64'(ed[i]));
    end
  endtask

  initial begin
    vec_t tbl[6];
    vec_t rv;
    tbl[0] = '{0, 12'h000, 12'h100, 11'd4, 32'h0, 0, 13, 12, 0, 0, "copy4"};
    tbl[1] = '{1, 12'h000, 12'h040, 11'd3, 32'hDEADBEEF, 2, -1, -1, 0, 0, "fill_stall"};
    tbl[2] = '{0, 12'h123, 12'h456, 11'd0, 32'h0, 0, 1, 0, 0, 0, "n0"};
    tbl[3] = '{0, 12'h200, 12'hFF8, 11'd4, 32'h0, 0, 13, 12, 0, 0, "copy_wrap"};
    tbl[4] = '{1, 12'h000, 12'h300, 11'd5, 32'hA5A5_0F0F, 0, 6, 5, 1, 1, "restart_ignored"};
    tbl[5] = '{0, 12'h013, 12'h0E2, 11'd2, 32'h0, 0, 7, 6, 0, 0, "unaligned"};
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst busy", 64'(busy), 0);
    chk("rst done", 64'(done), 0);
    chk("rst read", 64'(avm_read), 0);
    chk("rst write", 64'(avm_write), 0);
    chk("rst addr", 64'(avm_address), 0);
    chk("rst wdata", 64'(avm_writedata), 0);
    chk("byteenable", 64'(avm_byteenable), 64'hF);
    lat = 1;
    for (int i = 0; i < 6; i++) run_job(tbl[i]);
    // Randomized jobs: random stalls, read latency 1..3, spurious readdatavalid
    lat = 0; spur = 1;
    for (int i = 0; i < 10; i++) begin
      rv = '{1'($urandom), 12'($urandom), 12'($urandom), 11'($urandom_range(12, 1)), $urandom,
             1, -1, -1, 0, 0, $sformatf("rand%0d", i)};
      run_job(rv);
    end
    // Reset while waiting for read data; the late readdatavalid must be ignored
    spur = 0; lat = 5; stall_mode = 0;
    @(negedge clk);
    wq_a.delete(); wq_d.delete();
    start = 1; mode = 0; src_base = 12'h010; dst_base = 12'h080; word_count = 11'd2;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("rdwait busy", 64'(busy), 1);
    chk("rdwait read low", 64'(avm_read), 0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("midrst busy", 64'(busy), 0);
    chk("midrst read", 64'(avm_read), 0);
    chk("midrst addr", 64'(avm_address), 0);
    chk("midrst wdata", 64'(avm_writedata), 0);
    begin
      int dn = 0, bz = 0;
      repeat (8) begin
        @(negedge clk);
        if (done) dn++;
        if (busy) bz++;
      end
      chk("midrst done", 64'(dn), 0);
      chk("midrst busy_later", 64'(bz), 0);
    end
    chk("midrst writes", 64'(wq_a.size()), 0);
    chk("midrst wdata_later", 64'(avm_writedata), 0);
    chk("protocol", 64'(n_viol), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
